// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - 6-digit multiplexed 7-segment scan for HH.MM.SS with per-frame snapshot.
// Optional set-mode field blinking is built when CLOCK_DISPLAY_BLINK_EN is defined.
module clock_display_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 500000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [4:0] i_hr,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_set,
  input  logic [1:0] i_field,
  output logic [5:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SCAN_W-1:0] presc, presc_nxt;
  logic              tick;
  logic [2:0]        idx, idx_nxt;
  logic              snap;
  logic [4:0]        sh_hr, sh_hr_nxt;
  logic [5:0]        sh_min, sh_min_nxt;
  logic [5:0]        sh_sec, sh_sec_nxt;
  logic [5:0]        field_val;
  logic              field_bad;
  logic [3:0]        tens, ones, digit;
  logic              blank;
  logic [5:0]        an_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    tick      = (presc == SCAN_W'(SCAN_DIV - 1));
    presc_nxt = tick ? '0 : presc + 1'b1;
    idx_nxt   = idx;
    if (tick) idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    // Capture only at the frame boundary so one frame never mixes two times.
    snap       = tick && (idx == 3'd5);
    sh_hr_nxt  = snap ? i_hr  : sh_hr;
    sh_min_nxt = snap ? i_min : sh_min;
    sh_sec_nxt = snap ? i_sec : sh_sec;
  end

  // Outputs are computed from next-state values so pins move with idx.
  always_comb begin
    field_val = 6'd0;
    field_bad = 1'b0;
    case (idx_nxt[2:1])
      2'd0: begin
        field_val = sh_sec_nxt;
        field_bad = (sh_sec_nxt >= 6'd60);
      end
      2'd1: begin
        field_val = sh_min_nxt;
        field_bad = (sh_min_nxt >= 6'd60);
      end
      default: begin
        field_val = {1'b0, sh_hr_nxt};
        field_bad = (sh_hr_nxt >= 5'd24);
      end
    endcase
  end

  always_comb begin
    if      (field_val >= 6'd60) tens = 4'd6;
    else if (field_val >= 6'd50) tens = 4'd5;
    else if (field_val >= 6'd40) tens = 4'd4;
    else if (field_val >= 6'd30) tens = 4'd3;
    else if (field_val >= 6'd20) tens = 4'd2;
    else if (field_val >= 6'd10) tens = 4'd1;
    else                         tens = 4'd0;
    ones    = 4'(field_val - 6'(tens) * 6'd10);
    digit   = idx_nxt[0] ? tens : ones;
    an_nxt  = 6'b000001 << idx_nxt;
    dp_nxt  = (idx_nxt == 3'd2) || (idx_nxt == 3'd4);
    seg_nxt = blank ? 7'b0000000 : (field_bad ? 7'b1000000 : seg7(digit));
  end

`ifdef CLOCK_DISPLAY_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic               phase, phase_nxt;

  always_comb begin
    blink_cnt_nxt = '0;
    phase_nxt     = 1'b0;
    if (i_set) begin
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_nxt = '0;
        phase_nxt     = ~phase;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
        phase_nxt     = phase;
      end
    end
    blank = phase_nxt && (i_field != 2'd3) && (i_field == idx_nxt[2:1]);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
    end
  end
`else
  logic unused_blink_inputs;
  assign unused_blink_inputs = ^{i_set, i_field};
  assign blank = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      presc  <= '0;
      idx    <= 3'd0;
      sh_hr  <= 5'd0;
      sh_min <= 6'd0;
      sh_sec <= 6'd0;
      o_an   <= 6'b000001;
      o_seg  <= 7'b0111111;
      o_dp   <= 1'b0;
    end else begin
      presc  <= presc_nxt;
      idx    <= idx_nxt;
      sh_hr  <= sh_hr_nxt;
      sh_min <= sh_min_nxt;
      sh_sec <= sh_sec_nxt;
      o_an   <= an_nxt;
      o_seg  <= seg_nxt;
      o_dp   <= dp_nxt;
    end
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream stage of the clock core; consumes its binary hour/minute/second outputs.
- Drives a 6-digit multiplexed 7-segment display (HH.MM.SS).
- Converts each field to two BCD digits and scans one digit at a time at a prescaled rate.
- Snapshots the time once per scan frame, so a frame never mixes two different time values.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit is shown; minimum 1; 1 means advance every cycle.
- BLINK_DIV, 500000: clock cycles per blink half-period; minimum 1; used only with BLINK_EN.

Ports:
- i_clk  in  1  system clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_hr  in  5  hours, binary, valid 0-23.
- i_min  in  6  minutes, binary, valid 0-59.
- i_sec  in  6  seconds, binary, valid 0-59.
- i_set  in  1  set mode active (blink enable).
- i_field  in  2  field being edited: 0=sec, 1=min, 2=hr, 3=none.
- o_an  out  6  digit select, one-hot, active-high; bit0 = rightmost digit.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- o_dp  out  1  decimal point, active-high.

Behaviour:
- Clock and reset: one clock, i_clk. i_rstn is asynchronous, active-low. All state clears immediately on assertion.
- Reset values: prescaler=0, idx=0, shadow hr/min/sec=0, blink counter=0, phase=0, o_an=6'b000001, o_seg=7'b0111111 ('0'), o_dp=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted in the cycle where prescaler==SCAN_DIV-1.
- Digit index:
  - idx advances on the clock edge ending a tick cycle.
  - Sequence is 0,1,2,3,4,5,0.
- Snapshot:
  - On the tick edge where idx wraps 5->0, shadow regs capture i_hr/i_min/i_sec.
  - Inputs are ignored at all other times.
  - Worst-case latency from an input change to display is 6*SCAN_DIV cycles.
- Digit mapping:
  - idx0 = sec ones, idx1 = sec tens.
  - idx2 = min ones, idx3 = min tens.
  - idx4 = hr ones, idx5 = hr tens.
- BCD: tens = value/10, ones = value%10. Divide-by-10 over the 6-bit range is combinational.
- Out of range: shadow sec/min >= 60 or hr >= 24 shows both digits of that field as dash, o_seg=7'b1000000.
- Segment codes:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Tens digit: the leading zero is displayed (e.g. 07), never blanked.
- o_dp: 1 when idx==2 or idx==4 (separator right of the MM and HH ones digits), else 0.
- Output registers:
  - o_an, o_seg and o_dp are registered.
  - They are loaded each cycle from the next-state idx, shadow and phase values.
  - They therefore change on the same edge as idx and the snapshot. No combinational glitches reach the pins.
- Reset mid-frame: outputs return to the reset values at once. Scanning restarts at idx0 with shadow=0.

Optional Feature:
- Macro: CLOCK_DISPLAY_BLINK_EN.
- Defined:
  - A blink counter runs only while i_set=1 and toggles phase every BLINK_DIV cycles.
  - While i_set=0 the counter and phase are held at 0.
  - When phase=1 and the current digit belongs to the field selected by i_field, o_seg=0. o_an and o_dp are unaffected.
  - i_field=3 never blanks.
  - A change of i_field takes effect on the next cycle, with no phase reset.
- Undefined: i_set and i_field are ignored. No blink counter is synthesized.

Test Plan:
All scenarios use SCAN_DIV=4, BLINK_DIV=8.
1. Reset: hold i_rstn=0 for 3 cycles with arbitrary inputs -> o_an=000001, o_seg=0111111, o_dp=0 throughout. Release -> idx advances every 4 cycles.
2. Full frame: apply hr=23, min=59, sec=7 and wait for the snapshot. Next frame must show:
   - idx0 o_an=000001, seg 0000111
   - idx1 o_an=000010, seg 0111111
   - idx2 o_an=000100, seg 1101111, dp=1
   - idx3 o_an=001000, seg 1101101
   - idx4 o_an=010000, seg 1001111, dp=1
   - idx5 o_an=100000, seg 1011011
   Each digit holds exactly 4 cycles.
3. Mid-frame change: change sec 7->8 while idx=3 -> idx0/idx1 of the current frame are unaffected. The next frame idx0 shows 1111111.
4. Out-of-range: min=60, hr=24 -> idx2..idx5 all show 1000000. Sec digits remain correct.
5. Blink (macro defined): i_set=1, i_field=1.
   - idx2/idx3 show seg=0 during alternate 8-cycle windows; o_an still one-hot.
   - Then i_field=3 -> no blanking.
   - Then i_set=0 -> phase=0, no blanking.
   - Macro undefined -> never blanks.
6. Reset mid-frame: assert i_rstn at idx4 -> outputs show the reset values asynchronously. After release, scanning restarts at idx0 with all digits 0 until the next snapshot.
